// File: rtl/arbitro_memoria_if.sv
// Bus between the CPU request ports, the memory arbiter and the shared memory.
// slave = arbiter view, master = CPU/memory side (testbench).
interface arbitro_memoria_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        if_erro;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        dm_erro;
    logic [31:0] endereco;
    logic [31:0] indata;
    logic        lerMem;
    logic        escMem;
    logic [31:0] output_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, output_mem,
        output if_done, if_data, if_erro, dm_done, dm_rdata, dm_erro,
        output endereco, indata, lerMem, escMem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, output_mem,
        input  if_done, if_data, if_erro, dm_done, dm_rdata, dm_erro,
        input  endereco, indata, lerMem, escMem
    );
endinterface

// File: rtl/arbitro_memoria.sv
// Fetch/load-store arbiter in front of the shared MIPS memory: one access at a
// time, three cycles each (grant, strobe, capture), with address fault checks.
module arbitro_memoria #(
    parameter int PALAVRAS  = 512,
    parameter int MAX_DADOS = 4
) (
    input logic              clock,
    input logic              reset,
    arbitro_memoria_if.slave bus
);
    localparam int          AW     = $clog2(PALAVRAS);
    localparam int          CW     = $clog2(MAX_DADOS + 1);
    localparam logic [31:0] LIMITE = 32'(4 * PALAVRAS);

    typedef enum logic [1:0] {OCIOSO, ACESSO, CAPTURA} estado_t;

    estado_t         estado_q, estado_d;
    logic            porta_q, porta_d;   // 1 = data port, 0 = fetch
    logic            we_q, we_d;
    logic            falha_q, falha_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     endereco_q, endereco_d, indata_q, indata_d;
    logic            ler_q, ler_d, esc_q, esc_d;
    logic            if_done_q, if_done_d, if_erro_q, if_erro_d;
    logic            dm_done_q, dm_done_d, dm_erro_q, dm_erro_d;
    logic [31:0]     if_data_q, if_data_d, dm_rdata_q, dm_rdata_d;

    logic            grant_dm, grant_if, we_sel, falha_sel;
    logic [31:0]     addr_sel;

    // Data wins unless a waiting fetch has already seen MAX_DADOS data grants.
    assign grant_dm  = bus.dm_req && !(bus.if_req && cnt_q == CW'(MAX_DADOS));
    assign grant_if  = bus.if_req && !grant_dm;
    assign addr_sel  = grant_dm ? bus.dm_addr : bus.if_addr;
    assign we_sel    = grant_dm && bus.dm_we;
    assign falha_sel = (addr_sel[1:0] != 2'b00) || (addr_sel >= LIMITE);

    always_comb begin
        estado_d   = estado_q;
        porta_d    = porta_q;
        we_d       = we_q;
        falha_d    = falha_q;
        cnt_d      = cnt_q;
        endereco_d = endereco_q;
        indata_d   = indata_q;
        ler_d      = 1'b0;
        esc_d      = 1'b0;
        if_done_d  = 1'b0;
        if_erro_d  = 1'b0;
        if_data_d  = 32'h0;
        dm_done_d  = 1'b0;
        dm_erro_d  = 1'b0;
        dm_rdata_d = 32'h0;
        case (estado_q)
            OCIOSO: begin
                if (grant_dm || grant_if) begin
                    estado_d   = ACESSO;
                    porta_d    = grant_dm;
                    we_d       = we_sel;
                    falha_d    = falha_sel;
                    endereco_d = 32'(addr_sel[AW+1:2]);
                    indata_d   = grant_dm ? bus.dm_wdata : 32'h0;
                    ler_d      = !falha_sel && !we_sel;
                    esc_d      = !falha_sel && we_sel;
                    if (grant_dm && bus.if_req)
                        cnt_d = (cnt_q == CW'(MAX_DADOS)) ? cnt_q : cnt_q + CW'(1);
                    else
                        cnt_d = '0;
                end
            end
            ACESSO: begin
                estado_d = CAPTURA;
                if (porta_q) begin
                    dm_done_d  = 1'b1;
                    dm_erro_d  = falha_q;
                    dm_rdata_d = (!we_q && !falha_q) ? bus.output_mem : 32'h0;
                end else begin
                    if_done_d  = 1'b1;
                    if_erro_d  = falha_q;
                    if_data_d  = falha_q ? 32'h0 : bus.output_mem;
                end
            end
            CAPTURA: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            porta_q    <= 1'b0;
            we_q       <= 1'b0;
            falha_q    <= 1'b0;
            cnt_q      <= '0;
            endereco_q <= 32'h0;
            indata_q   <= 32'h0;
            ler_q      <= 1'b0;
            esc_q      <= 1'b0;
            if_done_q  <= 1'b0;
            if_erro_q  <= 1'b0;
            if_data_q  <= 32'h0;
            dm_done_q  <= 1'b0;
            dm_erro_q  <= 1'b0;
            dm_rdata_q <= 32'h0;
        end else begin
            estado_q   <= estado_d;
            porta_q    <= porta_d;
            we_q       <= we_d;
            falha_q    <= falha_d;
            cnt_q      <= cnt_d;
            endereco_q <= endereco_d;
            indata_q   <= indata_d;
            ler_q      <= ler_d;
            esc_q      <= esc_d;
            if_done_q  <= if_done_d;
            if_erro_q  <= if_erro_d;
            if_data_q  <= if_data_d;
            dm_done_q  <= dm_done_d;
            dm_erro_q  <= dm_erro_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.endereco = endereco_q;
    assign bus.indata   = indata_q;
    assign bus.lerMem   = ler_q;
    assign bus.escMem   = esc_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_erro  = if_erro_q;
    assign bus.if_data  = if_data_q;
    assign bus.dm_done  = dm_done_q;
    assign bus.dm_erro  = dm_erro_q;
    assign bus.dm_rdata = dm_rdata_q;
endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria with a 512-word async-read memory model.
module tb_arbitro_memoria;
    logic clock = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] mem [0:511];

    arbitro_memoria_if bus();

    arbitro_memoria #(.PALAVRAS(512), .MAX_DADOS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (bus.escMem) mem[bus.endereco[8:0]] <= bus.indata;

    assign bus.output_mem = mem[bus.endereco[8:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One access from the OCIOSO point just after an edge; returns in OCIOSO.
    // Inputs are scrambled mid-flight to show they are ignored.
    task automatic acesso(input logic dm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_end,
                          input logic [31:0] exp_data, input logic exp_erro);
        if (dm) begin
            bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        @(posedge clock); #1;
        chk("lerMem_acesso", 32'(bus.lerMem), 32'(!exp_erro && !we));
        chk("escMem_acesso", 32'(bus.escMem), 32'(!exp_erro && we));
        chk("endereco", bus.endereco, exp_end);
        chk("done_early", 32'({bus.if_done, bus.dm_done}), 32'h0);
        if (dm) begin
            bus.dm_addr = ~addr; bus.dm_wdata = ~wdata; bus.dm_we = ~we;
        end
        @(posedge clock); #1;
        chk("done", 32'({bus.if_done, bus.dm_done}), dm ? 32'h1 : 32'h2);
        chk("data", dm ? bus.dm_rdata : bus.if_data, exp_data);
        chk("erro", 32'(dm ? bus.dm_erro : bus.if_erro), 32'(exp_erro));
        chk("strobe_captura", 32'({bus.lerMem, bus.escMem}), 32'h0);
        chk("endereco_held", bus.endereco, exp_end);
        @(posedge clock); #1;
        chk("ocioso", 32'({bus.if_done, bus.dm_done, bus.lerMem, bus.escMem}), 32'h0);
    endtask

    initial begin
        logic [9:0] seq_dm;
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h10; bus.dm_wdata = 32'h1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_done", 32'({bus.if_done, bus.dm_done}), 32'h0);
        chk("rst_strobe", 32'({bus.lerMem, bus.escMem}), 32'h0);
        chk("rst_erro", 32'({bus.if_erro, bus.dm_erro}), 32'h0);
        chk("rst_endereco", bus.endereco, 32'h0);
        chk("rst_indata", bus.indata, 32'h0);
        chk("rst_data", bus.if_data | bus.dm_rdata, 32'h0);
        reset = 1'b0; bus.dm_req = 1'b0;

        // store then load
        acesso(1, 1, 32'h10, 32'hDEADBEEF, 32'd4, 32'h0, 0);
        bus.dm_req = 1'b0;
        acesso(1, 0, 32'h10, 32'h0, 32'd4, 32'hDEADBEEF, 0);
        bus.dm_req = 1'b0;

        // preload fetch words
        acesso(1, 1, 32'h0, 32'h2402000A, 32'd0, 32'h0, 0);
        acesso(1, 1, 32'h4, 32'h0000000C, 32'd1, 32'h0, 0);
        bus.dm_req = 1'b0;

        // back-to-back fetch with if_req held
        acesso(0, 0, 32'h0, 32'h0, 32'd0, 32'h2402000A, 0);
        acesso(0, 0, 32'h4, 32'h0, 32'd1, 32'h0000000C, 0);
        bus.if_req = 1'b0;

        // faults: misaligned store, out-of-range load
        acesso(1, 1, 32'h13, 32'h12345678, 32'd4, 32'h0, 1);
        acesso(1, 0, 32'h800, 32'h0, 32'd0, 32'h0, 1);
        bus.dm_req = 1'b0;
        chk("mem_after_fault", mem[4], 32'hDEADBEEF);
        // fetch fault
        acesso(0, 0, 32'h6, 32'h0, 32'd1, 32'h0, 1);
        bus.if_req = 1'b0;

        // top word boundary
        acesso(1, 1, 32'h7FC, 32'hCAFEF00D, 32'd511, 32'h0, 0);
        acesso(1, 0, 32'h7FC, 32'h0, 32'd511, 32'hCAFEF00D, 0);
        bus.dm_req = 1'b0;

        // contention: expect D,D,D,D,I,D,D,D,D,I (bit i = access i, 1 = data)
        seq_dm = 10'b01111_01111;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); @(posedge clock); #1;
            chk($sformatf("grant%0d", i), 32'({bus.if_done, bus.dm_done}),
                seq_dm[i] ? 32'h1 : 32'h2);
            chk($sformatf("grant_data%0d", i), seq_dm[i] ? bus.dm_rdata : bus.if_data,
                seq_dm[i] ? 32'hDEADBEEF : 32'h2402000A);
            @(posedge clock); #1;
        end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        @(posedge clock); @(posedge clock); @(posedge clock); #1;

        // reset during ACESSO of a strobed store: write lands, no done
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'hA5A5A5A5;
        @(posedge clock); #1;
        chk("rst_mid_esc", 32'(bus.escMem), 32'h1);
        reset = 1'b1; bus.dm_req = 1'b0;
        @(posedge clock); #1;
        chk("rst_mid_done", 32'({bus.if_done, bus.dm_done}), 32'h0);
        chk("rst_mid_strobe", 32'({bus.lerMem, bus.escMem}), 32'h0);
        chk("rst_mid_endereco", bus.endereco, 32'h0);
        chk("rst_mid_mem", mem[8], 32'hA5A5A5A5);
        @(posedge clock); #1;
        chk("rst_mid_nodone", 32'({bus.if_done, bus.dm_done}), 32'h0);
        reset = 1'b0;
        acesso(1, 0, 32'h20, 32'h0, 32'd8, 32'hA5A5A5A5, 0);
        bus.dm_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
